branch_resolve_unit: RTL and testbench

- Parametrised, pipelined branch resolution unit for the RISC-V core, successor to the single-cycle combinational branch comparator.
- Accepts a branch micro-op (operands, funct3, PC, immediate, prediction) over a valid/ready handshake and evaluates all six RV32I/RV64I branch conditions.
- Over a 2-stage pipeline it computes the target, taken/not-taken, mispredict, fall-through redirect PC and misalignment.
- Keeps saturating performance counters for resolved branches and mispredicts; sits at the EX stage output, feeding the fetch redirect logic.

---
 rtl/riscv_branch_pkg.sv | 29 ++
 rtl/branch_resolve_unit_if.sv | 36 +++
 rtl/branch_flags_xlen.sv | 19 +
 rtl/branch_resolve_unit.sv | 110 +++++++++++
 tb/tb_branch_resolve_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_branch_pkg.sv
// Shared RV32I/RV64I branch definitions: funct3 encodings and the condition decode.
package riscv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Reserved encodings resolve as not-taken and are flagged illegal.
  function automatic logic cond_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt_s, input logic lt_u);
    case (f3)
      F3_BEQ:  return eq;
      F3_BNE:  return !eq;
      F3_BLT:  return lt_s;
      F3_BGE:  return !lt_s;
      F3_BLTU: return lt_u;
      F3_BGEU: return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch micro-op request and resolution result channels with valid/ready handshakes.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_op1;
  logic [XLEN-1:0] in_op2;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_misaligned;
  logic            out_illegal;

  modport master (
    output in_valid, in_op1, in_op2, in_funct3, in_pc, in_imm, in_pred_taken,
           in_pred_target, flush, out_ready,
    input  in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc,
           out_misaligned, out_illegal
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_funct3, in_pc, in_imm, in_pred_taken,
           in_pred_target, flush, out_ready,
    output in_ready, out_valid, out_taken, out_mispredict, out_redirect_pc,
           out_misaligned, out_illegal
  );
endinterface

// File: rtl/branch_flags_xlen.sv
// Operand comparison flags (equal, signed less-than, unsigned less-than).
module branch_flags_xlen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt_s,
  output logic            lt_u
);
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s  = a;
  assign b_s  = b;
  assign eq   = (a == b);
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);
endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: compare and address generation, then condition decode,
// mispredict detection and fetch redirect, with saturating resolve/mispredict counters.
module branch_resolve_unit
  import riscv_branch_pkg::*;
#(
  parameter int         XLEN       = 32,
  parameter int         CNT_W      = 32,
  parameter logic [1:0] ALIGN_MASK = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     cnt_branches,
  output logic [CNT_W-1:0]     cnt_mispredicts
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic            eq, lt_s, lt_u;
  logic            vld_p1, vld_p2;
  logic            eq_p1, lt_s_p1, lt_u_p1, pred_taken_p1;
  logic [2:0]      funct3_p1;
  logic [XLEN-1:0] target_p1, fall_p1, pred_target_p1;
  logic            taken_p2, mis_p2, misal_p2, illegal_p2;
  logic [XLEN-1:0] redirect_p2;
  logic            adv_p2, accept, out_fire;
  logic            taken_c, mis_c, misal_c;

  branch_flags_xlen #(.XLEN(XLEN)) u_flags (
    .a    (bus.in_op1),
    .b    (bus.in_op2),
    .eq   (eq),
    .lt_s (lt_s),
    .lt_u (lt_u)
  );

  assign adv_p2       = !vld_p2 || bus.out_ready;
  assign bus.in_ready = !vld_p1 || adv_p2;
  assign accept       = bus.in_valid && bus.in_ready;
  // A result leaving during a flush is killed, so it is not counted.
  assign out_fire     = vld_p2 && bus.out_ready && !bus.flush;

  assign taken_c = cond_taken(funct3_p1, eq_p1, lt_s_p1, lt_u_p1);
  assign mis_c   = (taken_c != pred_taken_p1) ||
                   (taken_c && (pred_target_p1 != target_p1));
  assign misal_c = taken_c && ((target_p1[1:0] & ALIGN_MASK) != 2'b00);

  // Stage 1: capture compare flags and both candidate PCs
  always_ff @(posedge clk) begin
    if (accept) begin
      eq_p1          <= eq;
      lt_s_p1        <= lt_s;
      lt_u_p1        <= lt_u;
      target_p1      <= bus.in_pc + bus.in_imm;
      fall_p1        <= bus.in_pc + XLEN'(4);
      funct3_p1      <= bus.in_funct3;
      pred_taken_p1  <= bus.in_pred_taken;
      pred_target_p1 <= bus.in_pred_target;
    end
  end

  // Stage 2: resolved outcome, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      taken_p2    <= 1'b0;
      mis_p2      <= 1'b0;
      misal_p2    <= 1'b0;
      illegal_p2  <= 1'b0;
      redirect_p2 <= '0;
    end else begin
      if (bus.flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        if (bus.in_ready) vld_p1 <= bus.in_valid;
        if (adv_p2)       vld_p2 <= vld_p1;
      end
      if (adv_p2 && vld_p1) begin
        taken_p2    <= taken_c;
        mis_p2      <= mis_c;
        misal_p2    <= misal_c;
        illegal_p2  <= f3_illegal(funct3_p1);
        redirect_p2 <= taken_c ? target_p1 : fall_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_branches    <= '0;
      cnt_mispredicts <= '0;
    end else if (out_fire) begin
      cnt_branches <= sat_inc(cnt_branches);
      if (mis_p2) cnt_mispredicts <= sat_inc(cnt_mispredicts);
    end
  end

  assign bus.out_valid       = vld_p2;
  assign bus.out_taken       = taken_p2;
  assign bus.out_mispredict  = mis_p2;
  assign bus.out_redirect_pc = redirect_p2;
  assign bus.out_misaligned  = misal_p2;
  assign bus.out_illegal     = illegal_p2;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus stall, flush, saturation and reset sequences.
module tb_branch_resolve_unit;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] op1, op2, pc, imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        taken, mis;
    logic [31:0] redir;
    logic        misal, ill;
  } vec_t;

  localparam int NV = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_clear;
  logic [3:0] cnt_branches, cnt_mispredicts;
  int         total = 0;
  int         bad = 0;
  vec_t       tab[NV];

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(.XLEN(32), .CNT_W(4), .ALIGN_MASK(2'b11)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .cnt_clear       (cnt_clear),
    .cnt_branches    (cnt_branches),
    .cnt_mispredicts (cnt_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                              input logic [31:0] ptgt, input logic taken, input logic mis,
                              input logic [31:0] redir, input logic misal, input logic ill);
    vec_t v;
    v.f3 = f3; v.op1 = op1; v.op2 = op2; v.pc = pc; v.imm = imm; v.pt = pt; v.ptgt = ptgt;
    v.taken = taken; v.mis = mis; v.redir = redir; v.misal = misal; v.ill = ill;
    return v;
  endfunction

  task automatic drive_vec(input int i);
    bus.in_funct3      = tab[i].f3;
    bus.in_op1         = tab[i].op1;
    bus.in_op2         = tab[i].op2;
    bus.in_pc          = tab[i].pc;
    bus.in_imm         = tab[i].imm;
    bus.in_pred_taken  = tab[i].pt;
    bus.in_pred_target = tab[i].ptgt;
  endtask

  task automatic chk_out(input string tag, input int i);
    chk({tag, "_taken"}, bus.out_taken, tab[i].taken);
    chk({tag, "_mis"}, bus.out_mispredict, tab[i].mis);
    chk({tag, "_redir"}, bus.out_redirect_pc, tab[i].redir);
    chk({tag, "_misal"}, bus.out_misaligned, tab[i].misal);
    chk({tag, "_ill"}, bus.out_illegal, tab[i].ill);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
  endtask

  initial begin
    int waited, idx_in, idx_out, rel, first_stall, cyc, acc, exp_b, exp_m;

    //          f3      op1           op2           pc            imm           pt  ptgt          tk mis redir        mal ill
    tab[0]  = mk(3'b100, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       0, 32'h0,        1, 1, 32'h120,      0, 0);
    tab[1]  = mk(3'b110, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h20,       0, 32'h0,        0, 0, 32'h104,      0, 0);
    tab[2]  = mk(3'b000, 32'h5,        32'h5,        32'h100,      32'h20,       1, 32'h124,      1, 1, 32'h120,      0, 0);
    tab[3]  = mk(3'b000, 32'h5,        32'h5,        32'h100,      32'h20,       1, 32'h120,      1, 0, 32'h120,      0, 0);
    tab[4]  = mk(3'b001, 32'h5,        32'h5,        32'h200,      32'h8,        0, 32'h0,        0, 0, 32'h204,      0, 0);
    tab[5]  = mk(3'b101, 32'h1,        32'hFFFFFFFF, 32'h300,      32'hFFFFFFF0, 1, 32'h2F0,      1, 0, 32'h2F0,      0, 0);
    tab[6]  = mk(3'b111, 32'h1,        32'hFFFFFFFF, 32'h300,      32'hFFFFFFF0, 1, 32'h2F0,      0, 1, 32'h304,      0, 0);
    tab[7]  = mk(3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h400,      32'h6,        0, 32'h0,        1, 1, 32'h406,      1, 0);
    tab[8]  = mk(3'b010, 32'h1,        32'h1,        32'h500,      32'h10,       1, 32'h510,      0, 1, 32'h504,      0, 1);
    tab[9]  = mk(3'b011, 32'h0,        32'h0,        32'h500,      32'h2,        0, 32'h0,        0, 0, 32'h504,      0, 1);
    tab[10] = mk(3'b001, 32'h3,        32'h4,        32'hFFFFFFFC, 32'h8,        1, 32'h4,        1, 0, 32'h4,        0, 0);
    tab[11] = mk(3'b000, 32'h1,        32'h2,        32'hFFFFFFFC, 32'h10,       0, 32'h0,        0, 0, 32'h0,        0, 0);
    tab[12] = mk(3'b101, 32'h7,        32'h7,        32'h10,       32'h10,       0, 32'h0,        1, 1, 32'h20,       0, 0);

    rst = 1'b1; cnt_clear = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive_vec(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_taken", bus.out_taken, 0);
    chk("rst_mis", bus.out_mispredict, 0);
    chk("rst_redir", bus.out_redirect_pc, 0);
    chk("rst_ill", bus.out_illegal, 0);
    chk("rst_cnt_b", cnt_branches, 0);
    chk("rst_cnt_m", cnt_mispredicts, 0);

    exp_b = 0; exp_m = 0;
    for (int i = 0; i < NV; i++) begin
      drive_vec(i);
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      waited = 0;
      while (!bus.out_valid && waited < 8) begin
        step();
        waited++;
      end
      chk($sformatf("v%0d_latency", i), waited, 1);
      chk_out($sformatf("v%0d", i), i);
      step();
      exp_b++;
      if (tab[i].mis) exp_m++;
    end
    chk("tab_cnt_b", cnt_branches, exp_b);
    chk("tab_cnt_m", cnt_mispredicts, exp_m);

    // Backpressure: four ops offered back to back, consumer stalls 3 cycles after first result.
    clear_counters();
    idx_in = 0; idx_out = 0; rel = -1; first_stall = -1; cyc = 0;
    while (idx_out < 4 && cyc < 40) begin
      bus.in_valid = (idx_in < 4);
      if (idx_in < 4) drive_vec(idx_in);
      bus.out_ready = (rel >= 0 && cyc >= rel);
      @(negedge clk);
      if (bus.out_valid && rel < 0) rel = cyc + 3;
      if (bus.in_valid && !bus.in_ready && first_stall < 0) first_stall = idx_in;
      if (bus.out_valid && !bus.out_ready) begin
        chk($sformatf("bp_hold%0d_redir", idx_out), bus.out_redirect_pc, tab[idx_out].redir);
        chk($sformatf("bp_hold%0d_mis", idx_out), bus.out_mispredict, tab[idx_out].mis);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk_out($sformatf("bp%0d", idx_out), idx_out);
        idx_out++;
      end
      if (bus.in_valid && bus.in_ready) idx_in++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp_drained", idx_out, 4);
    chk("bp_stall_after", first_stall, 2);
    chk("bp_cnt_b", cnt_branches, 4);
    chk("bp_cnt_m", cnt_mispredicts, 2);

    // Flush with two ops in flight and a third being offered.
    clear_counters();
    drive_vec(0); bus.in_valid = 1'b1;
    step();
    drive_vec(1);
    step();
    chk("fl_pre_valid", bus.out_valid, 1);
    drive_vec(2); bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fl_valid%0d", k), bus.out_valid, 0);
      step();
    end
    chk("fl_cnt_b", cnt_branches, 0);
    chk("fl_cnt_m", cnt_mispredicts, 0);

    // Saturation: 20 streamed mispredicts (BNE on equal operands, predicted taken).
    clear_counters();
    bus.in_funct3 = 3'b001; bus.in_op1 = 32'h9; bus.in_op2 = 32'h9;
    bus.in_pc = 32'h600; bus.in_imm = 32'h40; bus.in_pred_taken = 1'b1; bus.in_pred_target = 32'h640;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("sat_accepts", acc, 20);
    chk("sat_cnt_b", cnt_branches, 15);
    chk("sat_cnt_m", cnt_mispredicts, 15);

    // Clear coinciding with an output handshake.
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("clr_pre_valid", bus.out_valid, 1);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    chk("clr_cnt_b", cnt_branches, 0);
    chk("clr_cnt_m", cnt_mispredicts, 0);

    // Reset while an op is in flight.
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mrst_valid%0d", k), bus.out_valid, 0);
      step();
    end
    chk("mrst_cnt_b", cnt_branches, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
